// File: rtl/cr_axi4s_frm_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cr_axi4s_frm_chk_pkg
//  Brief    : Shared types for the AXI4-stream frame checker: datapath beat,
//             per-frame status record and checker FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cr_axi4s_frm_chk_pkg;

    // Project-wide ceiling on frame length; status fields are sized from it
    localparam int CR_MAX_FRM_BEATS = 4096;
    localparam int CR_BEAT_W        = $clog2(CR_MAX_FRM_BEATS + 1);
    localparam int CR_BYTE_W        = CR_BEAT_W + 3;

    typedef struct packed {
        logic        tlast;
        logic [7:0]  tstrb;
        logic [63:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic [CR_BEAT_W-1:0] beats;
        logic [CR_BYTE_W-1:0] bytes;
        logic                 err;
    } frm_stat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } frm_state_t;

endpackage
`default_nettype wire

// File: rtl/cr_axi4s_frm_chk_if.sv
`default_nettype none
// ============================================================================
//  Module   : cr_axi4s_frm_chk_if
//  Brief    : FIFO-head, forwarded-beat and frame-status signal bundle of the
//             frame checker. slv is the checker side, mst the environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface cr_axi4s_frm_chk_if;
    import cr_axi4s_frm_chk_pkg::*;

    axi4s_dp_bus_t        axi4s_slv_out;
    logic                 axi4s_slv_empty;
    logic                 axi4s_slv_rd;
    axi4s_dp_bus_t        ob_data;
    logic                 ob_valid;
    logic                 ob_rdy;
    logic                 stat_valid;
    logic [CR_BEAT_W-1:0] stat_beats;
    logic [CR_BYTE_W-1:0] stat_bytes;
    logic                 stat_err;
    logic                 stat_rdy;

    modport slv (
        input  axi4s_slv_out, axi4s_slv_empty, ob_rdy, stat_rdy,
        output axi4s_slv_rd, ob_data, ob_valid,
        output stat_valid, stat_beats, stat_bytes, stat_err
    );

    modport mst (
        output axi4s_slv_out, axi4s_slv_empty, ob_rdy, stat_rdy,
        input  axi4s_slv_rd, ob_data, ob_valid,
        input  stat_valid, stat_beats, stat_bytes, stat_err
    );

endinterface
`default_nettype wire

// File: rtl/cr_popcnt8.sv
`default_nettype none
// ============================================================================
//  Module   : cr_popcnt8
//  Brief    : Combinational population count of an 8-bit byte strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module cr_popcnt8 (
    input  logic [7:0] strb,
    output logic [3:0] cnt
);

    // Sum the strobe bits
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, strb[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/cr_axi4s_frm_chk.sv
`default_nettype none
// ============================================================================
//  Module   : cr_axi4s_frm_chk
//  Brief    : Pops beats from an FWFT FIFO, forwards them through a registered
//             output stage, counts beats/bytes per frame and emits one status
//             record per frame. Oversize frames are cut at MAX_BEATS (tlast
//             forced, err set) and the rest of the frame is discarded.
//  Revision : 1.0 - initial release
// ============================================================================
module cr_axi4s_frm_chk
    import cr_axi4s_frm_chk_pkg::*;
#(
    // Must not exceed CR_MAX_FRM_BEATS, which sizes the status fields
    parameter int MAX_BEATS = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    cr_axi4s_frm_chk_if.slv bus
);

    localparam int                BEAT_W      = $clog2(MAX_BEATS + 1);
    localparam int                BYTE_W      = BEAT_W + 3;
    localparam logic [BEAT_W-1:0] C_MAX_BEATS = BEAT_W'(MAX_BEATS);

    frm_state_t        r_state;
    frm_state_t        w_state_nxt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [BYTE_W-1:0] w_byte_nxt;
    logic [3:0]        w_strb_cnt;
    logic              w_ob_free;
    logic              w_st_free;
    logic              w_limit;
    logic              w_closes;
    logic              w_can_take;
    logic              w_pop;
    logic              w_fwd;
    logic              w_emit;
    logic              w_trunc;
    axi4s_dp_bus_t     w_beat;
    axi4s_dp_bus_t     r_ob_data;
    logic              r_ob_valid;
    frm_stat_t         r_stat;
    logic              r_stat_valid;

    cr_popcnt8 u_popcnt (
        .strb (bus.axi4s_slv_out.tstrb),
        .cnt  (w_strb_cnt)
    );

    // Next-state, pop decision and the beat to forward
    always_comb begin
        w_state_nxt = r_state;
        w_can_take  = 1'b0;
        w_fwd       = 1'b0;
        w_emit      = 1'b0;
        w_trunc     = 1'b0;
        w_ob_free   = ~r_ob_valid | bus.ob_rdy;
        w_st_free   = ~r_stat_valid | bus.stat_rdy;
        w_beat_nxt  = r_beat_cnt + BEAT_W'(1);
        w_byte_nxt  = r_byte_cnt + BYTE_W'(w_strb_cnt);
        w_limit     = (w_beat_nxt == C_MAX_BEATS);
        // A closing beat also needs room in the status register
        w_closes    = bus.axi4s_slv_out.tlast | w_limit;
        case (r_state)
            ST_IDLE, ST_BODY: begin
                w_can_take = w_ob_free & (w_st_free | ~w_closes);
                if (~bus.axi4s_slv_empty & w_can_take) begin
                    w_fwd = 1'b1;
                    if (bus.axi4s_slv_out.tlast) begin
                        w_emit      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (w_limit) begin
                        w_emit      = 1'b1;
                        w_trunc     = 1'b1;
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_state_nxt = ST_BODY;
                    end
                end
            end
            ST_DROP: begin
                // Discarded beats bypass both output registers
                w_can_take = 1'b1;
                if (~bus.axi4s_slv_empty & bus.axi4s_slv_out.tlast) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_pop  = ~bus.axi4s_slv_empty & w_can_take;
        w_beat = bus.axi4s_slv_out;
        if (w_trunc) begin
            w_beat.tlast = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-frame beat and byte counters, cleared when a frame closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_byte_cnt <= '0;
        end else if (w_fwd) begin
            if (w_emit) begin
                r_beat_cnt <= '0;
                r_byte_cnt <= '0;
            end else begin
                r_beat_cnt <= w_beat_nxt;
                r_byte_cnt <= w_byte_nxt;
            end
        end
    end

    // Forwarded-beat register: load on pop, drain on accept, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ob_data  <= '0;
            r_ob_valid <= 1'b0;
        end else if (w_fwd) begin
            r_ob_data  <= w_beat;
            r_ob_valid <= 1'b1;
        end else if (bus.ob_rdy) begin
            r_ob_valid <= 1'b0;
        end
    end

    // Status register: loads with the closing beat, counts include that beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat       <= '0;
            r_stat_valid <= 1'b0;
        end else if (w_emit) begin
            r_stat.beats <= CR_BEAT_W'(w_beat_nxt);
            r_stat.bytes <= CR_BYTE_W'(w_byte_nxt);
            r_stat.err   <= w_trunc;
            r_stat_valid <= 1'b1;
        end else if (bus.stat_rdy) begin
            r_stat_valid <= 1'b0;
        end
    end

    assign bus.axi4s_slv_rd = w_pop;
    assign bus.ob_data      = r_ob_data;
    assign bus.ob_valid     = r_ob_valid;
    assign bus.stat_valid   = r_stat_valid;
    assign bus.stat_beats   = r_stat.beats;
    assign bus.stat_bytes   = r_stat.bytes;
    assign bus.stat_err     = r_stat.err;

endmodule
`default_nettype wire

// File: tb/tb_cr_axi4s_frm_chk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cr_axi4s_frm_chk
//  Brief    : Self-checking bench for cr_axi4s_frm_chk. Frames are described
//             at frame level; expected forwarded beats and status records are
//             derived from frame length, MAX_BEATS and the strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cr_axi4s_frm_chk;
    import cr_axi4s_frm_chk_pkg::*;

    localparam int MAX_BEATS = 4;

    typedef struct {
        axi4s_dp_bus_t beat;     // as presented at the FIFO head
        axi4s_dp_bus_t out;      // as it must appear on ob_data
        bit            fwd;      // within the first MAX_BEATS of its frame
        bit            closing;  // last forwarded beat of its frame
        frm_stat_t     stat;     // status record of its frame
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cr_axi4s_frm_chk_if bus ();

    cr_axi4s_frm_chk #(.MAX_BEATS(MAX_BEATS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t          fifo_q[$];
    axi4s_dp_bus_t exp_ob_q[$];
    frm_stat_t     exp_st_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            ob_mode  = 1;   // 0: hold low, 1: hold high, 2: random
    int            st_mode  = 1;
    bit            bubbles  = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic pick(input int mode);
        return (mode == 2) ? 1'($urandom_range(0, 1)) : (mode != 0);
    endfunction

    task automatic drive_head();
        bit gap;
        gap = bubbles && ($urandom_range(0, 3) == 0);
        bus.axi4s_slv_empty = (fifo_q.size() == 0) || gap;
        bus.axi4s_slv_out   = (fifo_q.size() != 0) ? fifo_q[0].beat : '0;
    endtask

    task automatic drive_inputs();
        drive_head();
        bus.ob_rdy   = pick(ob_mode);
        bus.stat_rdy = pick(st_mode);
    endtask

    // Queue one frame; strobes of beats 0..7 come from strbs unless rnd
    task automatic add_frame(input int len, input bit rnd, input logic [63:0] strbs);
        logic [7:0] strb_q[$];
        int         nfwd;
        int         bytes;
        ent_t       e;
        frm_stat_t  st;
        nfwd  = (len < MAX_BEATS) ? len : MAX_BEATS;
        bytes = 0;
        for (int i = 0; i < len; i++) begin
            if (rnd || i >= 8) strb_q.push_back(8'($urandom));
            else               strb_q.push_back(strbs[8*i +: 8]);
        end
        for (int i = 0; i < nfwd; i++) bytes += $countones(strb_q[i]);
        st.beats = CR_BEAT_W'(nfwd);
        st.bytes = CR_BYTE_W'(bytes);
        st.err   = (len > MAX_BEATS);
        for (int i = 0; i < len; i++) begin
            e.beat.tlast = (i == len - 1);
            e.beat.tstrb = strb_q[i];
            e.beat.tdata = {$urandom, $urandom};
            e.out        = e.beat;
            e.out.tlast  = (i == nfwd - 1);
            e.fwd        = (i < nfwd);
            e.closing    = (i == nfwd - 1);
            e.stat       = st;
            fifo_q.push_back(e);
            if (e.fwd) exp_ob_q.push_back(e.out);
        end
        exp_st_q.push_back(st);
        drive_head();
    endtask

    // One clock: check pop decision, then check what the edge produced
    task automatic cycle();
        logic          s_rd, s_empty, s_obv, s_obr, s_stv, s_str;
        logic          exp_rd, ob_free, st_free;
        axi4s_dp_bus_t s_obd;
        frm_stat_t     s_st, cur_st;
        ent_t          h;
        bit            popped;
        @(negedge clk);
        s_rd    = bus.axi4s_slv_rd;
        s_empty = bus.axi4s_slv_empty;
        s_obv   = bus.ob_valid;
        s_obr   = bus.ob_rdy;
        s_obd   = bus.ob_data;
        s_stv   = bus.stat_valid;
        s_str   = bus.stat_rdy;
        s_st    = {bus.stat_beats, bus.stat_bytes, bus.stat_err};
        ob_free = ~s_obv | s_obr;
        st_free = ~s_stv | s_str;
        exp_rd  = 1'b0;
        if (!s_empty) begin
            h      = fifo_q[0];
            exp_rd = h.fwd ? (ob_free & (st_free | ~h.closing)) : 1'b1;
        end
        check_eq("rd", s_rd, exp_rd);
        @(posedge clk);
        #1;
        popped = 1'b0;
        if (s_rd && !s_empty) begin
            h      = fifo_q.pop_front();
            popped = 1'b1;
        end
        if (s_obv && s_obr) begin
            if (exp_ob_q.size() == 0) check_eq("ob_extra_pending", exp_ob_q.size(), 1);
            else                      check_eq("ob_beat", s_obd, exp_ob_q.pop_front());
        end
        if (s_stv && s_str) begin
            if (exp_st_q.size() == 0) check_eq("st_extra_pending", exp_st_q.size(), 1);
            else                      check_eq("st_rec", s_st, exp_st_q.pop_front());
        end
        if (popped && h.fwd) begin
            check_eq("ob_load_v", bus.ob_valid, 1'b1);
            check_eq("ob_load_d", bus.ob_data, h.out);
        end else if (s_obv && !s_obr) begin
            check_eq("ob_hold_v", bus.ob_valid, 1'b1);
            check_eq("ob_hold_d", bus.ob_data, s_obd);
        end else begin
            check_eq("ob_idle_v", bus.ob_valid, 1'b0);
        end
        cur_st = {bus.stat_beats, bus.stat_bytes, bus.stat_err};
        if (popped && h.fwd && h.closing) begin
            check_eq("st_load_v", bus.stat_valid, 1'b1);
            check_eq("st_load", cur_st, h.stat);
        end else if (s_stv && !s_str) begin
            check_eq("st_hold_v", bus.stat_valid, 1'b1);
            check_eq("st_hold", cur_st, s_st);
        end else begin
            check_eq("st_idle_v", bus.stat_valid, 1'b0);
        end
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((fifo_q.size() != 0 || exp_ob_q.size() != 0 || exp_st_q.size() != 0) && guard < 500) begin
            cycle();
            guard++;
        end
        check_eq("drain_fifo", fifo_q.size(), 0);
        check_eq("drain_ob", exp_ob_q.size(), 0);
        check_eq("drain_st", exp_st_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_obv"}, bus.ob_valid, 1'b0);
        check_eq({tag, "_obd"}, bus.ob_data, '0);
        check_eq({tag, "_stv"}, bus.stat_valid, 1'b0);
        check_eq({tag, "_st"}, {bus.stat_beats, bus.stat_bytes, bus.stat_err}, '0);
    endtask

    // Reset asserted mid-frame; upstream FIFO is reset alongside
    task automatic do_reset_mid();
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        fifo_q.delete();
        exp_ob_q.delete();
        exp_st_q.delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mid_rd", bus.axi4s_slv_rd, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_inputs();
        #2;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();

        // 3-beat frame, strobes FF,FF,0F -> (3,20,0)
        add_frame(3, 1'b0, 64'h0F_FF_FF);
        drain();

        // back-to-back frames -> (1,1,0) then (2,9,0)
        add_frame(1, 1'b0, 64'h01);
        add_frame(2, 1'b0, 64'h80_FF);
        drain();

        // oversize 6-beat frame -> (4,32,1), then a fresh frame
        add_frame(6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        add_frame(2, 1'b1, 64'h0);
        drain();

        // output stalled for 5 cycles mid-frame
        add_frame(4, 1'b1, 64'h0);
        run(2);
        ob_mode = 0;
        drive_inputs();
        run(5);
        check_eq("ob_stall_fifo", fifo_q.size(), 2);
        ob_mode = 1;
        drive_inputs();
        drain();

        // status pending, closing beat must wait; earlier beats still flow
        st_mode = 0;
        drive_inputs();
        add_frame(1, 1'b1, 64'h0);
        add_frame(3, 1'b1, 64'h0);
        run(6);
        check_eq("st_stall_fifo", fifo_q.size(), 1);
        st_mode = 1;
        drive_inputs();
        drain();

        // reset mid-frame, then a clean 2-beat frame
        add_frame(4, 1'b1, 64'h0);
        run(2);
        do_reset_mid();
        add_frame(2, 1'b1, 64'h0);
        drain();

        // randomized frames, bubbles and back-pressure
        bubbles = 1'b1;
        ob_mode = 2;
        st_mode = 2;
        for (int f = 0; f < 80; f++) begin
            add_frame($urandom_range(1, 7), 1'b1, 64'h0);
            run($urandom_range(0, 4));
        end
        bubbles = 1'b0;
        ob_mode = 1;
        st_mode = 1;
        drive_inputs();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
